serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/fulladder.sv | 13 +
 rtl/serial_adder.sv | 125 ++++++++++++
 tb/tb_serial_adder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder used as the datapath of the serial adder.
module fulladder (
    output logic S,
    output logic Co,
    input  logic A,
    input  logic B,
    input  logic Ci
);

    assign S  = A ^ B ^ Ci;
    assign Co = (A & B) | (A & Ci) | (B & Ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one result bit per clock, LSB first,
// through a single full adder and a one-bit carry register.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic             SUB,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             V,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             co_q, co_d;
    logic             v_q, v_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic fa_s;
    logic fa_co;

    fulladder u_fa (
        .S  (fa_s),
        .Co (fa_co),
        .A  (a_q[0]),
        .B  (b_q[0]),
        .Ci (c_q)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        co_d    = co_q;
        v_d     = v_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // B is inverted up front so the datapath only ever adds
                    state_d = RUN;
                    a_d     = A;
                    b_d     = B ^ {WIDTH{SUB}};
                    c_d     = Ci ^ SUB;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                s_d   = {fa_s, s_q[WIDTH-1:1]};
                c_d   = fa_co;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    co_d    = fa_co;
                    v_d     = c_q ^ fa_co;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            co_q    <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            co_q    <= co_d;
            v_q     <= v_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign S    = s_q;
    assign Co   = co_q;
    assign V    = v_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Ci;
    logic         SUB;
    logic [W-1:0] S;
    logic         Co;
    logic         V;
    logic         busy;
    logic         done;

    int n_checks;
    int n_pass;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Ci    (Ci),
        .SUB   (SUB),
        .S     (S),
        .Co    (Co),
        .V     (V),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Returns {V, Co, S} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic ci, input logic sub);
        longint full = 64'd1 << W;
        longint half = 64'd1 << (W - 1);
        longint ua = longint'(a);
        longint ub = sub ? (full - 1 - longint'(b)) : longint'(b);
        longint cin = longint'(ci ^ sub);
        longint u = ua + ub + cin;
        longint sa = (ua >= half) ? ua - full : ua;
        longint sb = (ub >= half) ? ub - full : ub;
        longint st = sa + sb + cin;
        logic [W-1:0] s = W'(u % full);
        logic co = (u >= full);
        logic v = (st > half - 1) || (st < -half);
        return {v, co, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        A   = W'($urandom);
        B   = W'($urandom);
        Ci  = 1'($urandom);
        SUB = 1'($urandom);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sub, input bit glitch);
        logic [W+1:0] exp;
        exp   = model(a, b, ci, sub);
        A     = a;
        B     = b;
        Ci    = ci;
        SUB   = sub;
        start = 1'b1;
        tick();
        start = 1'b0;
        scramble();
        check("busy_after_start", busy, 1);
        for (int n = 1; n <= W; n++) begin
            tick();
            start = glitch && (n == 2 || n == 7 || n == W);
            scramble();
            if (n < W) begin
                check("busy_run", {busy, done}, 2'b10);
            end else begin
                check("done_pulse", {busy, done}, 2'b01);
                check("S", S, exp[W-1:0]);
                check("Co", Co, exp[W]);
                check("V", V, exp[W+1]);
            end
        end
        tick();
        start = 1'b0;
        check("done_drop", {busy, done}, 2'b00);
        check("hold", {V, Co, S}, exp);
        tick();
        check("idle", {busy, done}, 2'b00);
        check("hold2", {V, Co, S}, exp);
    endtask

    task automatic abort_op();
        bit saw_done;
        A     = W'($urandom);
        B     = W'($urandom);
        Ci    = 1'b1;
        SUB   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_clear", {busy, done, V, Co, S}, '0);
        saw_done = 0;
        for (int n = 0; n < 2 * W; n++) begin
            tick();
            if (done || busy) saw_done = 1;
        end
        check("abort_no_done", saw_done, 0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        A        = '0;
        B        = '0;
        Ci       = 1'b0;
        SUB      = 1'b0;
        tick();
        tick();
        check("reset", {busy, done, V, Co, S}, '0);
        rst = 1'b0;
        tick();

        run_op(8'h35, 8'h4A, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 0);
        run_op(8'h35, 8'h4A, 1'b1, 1'b0, 1);
        abort_op();
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   bit'($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
